// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle ARM-subset control unit
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECR   = 4'd6,
      S_EXECI   = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_EXECMUL = 4'd10,
      S_MULWB   = 4'd11
   } state_t;

   // ALUControl codes
   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_SUB   = 4'h1;
   localparam logic [3:0] ALU_AND   = 4'h2;
   localparam logic [3:0] ALU_ORR   = 4'h3;
   localparam logic [3:0] ALU_EOR   = 4'h4;
   localparam logic [3:0] ALU_MOV   = 4'h5;
   localparam logic [3:0] ALU_MUL   = 4'h8;
   localparam logic [3:0] ALU_UMULL = 4'h9;
   localparam logic [3:0] ALU_SMULL = 4'hA;

   // ALUSrcB selects
   localparam logic [1:0] SRCB_WDATA = 2'd0;
   localparam logic [1:0] SRCB_IMM   = 2'd1;
   localparam logic [1:0] SRCB_FOUR  = 2'd2;

   // ResultSrc selects
   localparam logic [1:0] RES_ALUOUT    = 2'd0;
   localparam logic [1:0] RES_DATA      = 2'd1;
   localparam logic [1:0] RES_ALURESULT = 2'd2;

   // ImmSrc selects
   localparam logic [1:0] IMM_ROT8  = 2'd0;
   localparam logic [1:0] IMM_12    = 2'd1;
   localparam logic [1:0] IMM_BR24  = 2'd2;

   // Instruction class (op field)
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Data-processing cmd field values
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   // MUL (000000) and UMULL/SMULL (00001x) share the 1001 marker in bits 7:4
   function automatic logic is_mul(input logic [31:0] instr);
      return ((instr[27:22] == 6'b000000) || (instr[27:23] == 5'b00001)) &&
             (instr[7:4] == 4'b1001);
   endfunction

   // DP cmd to ALU operation; unlisted cmds fall back to ADD
   function automatic logic [3:0] dp_alu_ctrl(input logic [3:0] cmd);
      case (cmd)
         CMD_ADD: return ALU_ADD;
         CMD_SUB: return ALU_SUB;
         CMD_CMP: return ALU_SUB;
         CMD_AND: return ALU_AND;
         CMD_EOR: return ALU_EOR;
         CMD_ORR: return ALU_ORR;
         CMD_MOV: return ALU_MOV;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - controller <-> datapath signal bundle
interface mc_controller_if;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        RegWrite;
   logic        IsLongMul;
   logic        MemWrite;
   logic        IRWrite;
   logic        AdrSrc;
   logic [1:0]  RegSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ResultSrc;
   logic [1:0]  ImmSrc;
   logic [3:0]  ALUControl;
   logic        opMul;
   logic [3:0]  state;
   logic [3:0]  Flags;
   logic        illegal;

   // controller side
   modport master (
      input  Instr, ALUFlags,
      output PCWrite, RegWrite, IsLongMul, MemWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, opMul, state,
             Flags, illegal
   );

   // datapath side
   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, RegWrite, IsLongMul, MemWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, opMul, state,
             Flags, illegal
   );
endinterface

// File: rtl/mc_controller_cond_check.sv
// rtl/mc_controller_cond_check.sv - ARM condition-code evaluation against NZCV
module cond_check
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_cond_ex
);

   logic w_n, w_z, w_c, w_v, w_ge;

   assign {w_n, w_z, w_c, w_v} = i_flags;
   assign w_ge = (w_n == w_v);

   // standard ARM condition table; 1111 never executes
   always_comb begin
      o_cond_ex = 1'b0;
      case (i_cond)
         COND_EQ: o_cond_ex = w_z;
         COND_NE: o_cond_ex = ~w_z;
         COND_CS: o_cond_ex = w_c;
         COND_CC: o_cond_ex = ~w_c;
         COND_MI: o_cond_ex = w_n;
         COND_PL: o_cond_ex = ~w_n;
         COND_VS: o_cond_ex = w_v;
         COND_VC: o_cond_ex = ~w_v;
         COND_HI: o_cond_ex = w_c & ~w_z;
         COND_LS: o_cond_ex = ~w_c | w_z;
         COND_GE: o_cond_ex = w_ge;
         COND_LT: o_cond_ex = ~w_ge;
         COND_GT: o_cond_ex = ~w_z & w_ge;
         COND_LE: o_cond_ex = w_z | ~w_ge;
         COND_AL: o_cond_ex = 1'b1;
         default: o_cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM-subset control unit: FSM, decoder, flags
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   mc_controller_if.master bus
);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_flags;
   logic        r_exec_cond;

   logic [1:0]  w_op;
   logic        w_i, w_s, w_u, w_l, w_long, w_signed, w_rd_pc;
   logic [3:0]  w_cmd;
   logic        w_is_mul, w_is_cmp, w_cond_ex, w_exec_state, w_flags_we;

   logic        w_pc_write, w_reg_write, w_long_wr, w_mem_write, w_ir_write;
   logic        w_adr_src, w_alu_src_a, w_illegal;
   logic [1:0]  w_reg_src, w_alu_src_b, w_result_src, w_imm_src;
   logic [3:0]  w_alu_ctrl;

   assign w_op     = bus.Instr[27:26];
   assign w_i      = bus.Instr[25];
   assign w_cmd    = bus.Instr[24:21];
   assign w_s      = bus.Instr[20];
   assign w_u      = bus.Instr[23];
   assign w_l      = bus.Instr[20];
   assign w_long   = bus.Instr[23];
   assign w_signed = bus.Instr[22];
   assign w_rd_pc  = (bus.Instr[15:12] == 4'd15);
   assign w_is_mul = is_mul(bus.Instr);
   assign w_is_cmp = (w_cmd == CMD_CMP);

   cond_check u_cond_check (
      .i_cond    (bus.Instr[31:28]),
      .i_flags   (r_flags),
      .o_cond_ex (w_cond_ex)
   );

   assign w_exec_state = (r_state == S_EXECR) || (r_state == S_EXECI) ||
                         (r_state == S_EXECMUL);
   assign w_flags_we   = w_exec_state && w_cond_ex &&
                         (w_s || (w_is_cmp && r_state != S_EXECMUL));

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // NZCV register, loaded when leaving an execute state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          r_flags <= 4'b0000;
      else if (w_flags_we) r_flags <= bus.ALUFlags;
   end

   // Condition result sampled in the execute state so a flag-setting
   // instruction's writeback is judged on the flags it started with
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            r_exec_cond <= 1'b0;
      else if (w_exec_state) r_exec_cond <= w_cond_ex;
   end

   // Next-state and per-state control outputs
   always_comb begin
      w_next       = S_FETCH;
      w_pc_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_long_wr    = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_adr_src    = 1'b0;
      w_reg_src    = 2'b00;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = SRCB_WDATA;
      w_result_src = RES_ALUOUT;
      w_imm_src    = IMM_ROT8;
      w_alu_ctrl   = ALU_ADD;
      w_illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ir_write   = 1'b1;
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALURESULT;
            w_pc_write   = 1'b1;
            w_next       = S_DECODE;
         end
         S_DECODE: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALURESULT;
            w_reg_src[0] = (w_op == OP_BR);
            w_reg_src[1] = (w_op == OP_MEM) && !w_l;
            if (w_op == OP_MEM)     w_next = S_MEMADR;
            else if (w_op == OP_BR) w_next = S_BRANCH;
            else if (w_is_mul)      w_next = S_EXECMUL;
            else if (w_op == OP_DP) w_next = w_i ? S_EXECI : S_EXECR;
            else begin
               w_next    = S_FETCH;
               w_illegal = 1'b1;
            end
         end
         S_MEMADR: begin
            w_alu_src_b = SRCB_IMM;
            w_imm_src   = IMM_12;
            w_alu_ctrl  = w_u ? ALU_ADD : ALU_SUB;
            w_next      = w_l ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_adr_src = 1'b1;
            w_next    = S_MEMWB;
         end
         S_MEMWB: begin
            w_result_src = RES_DATA;
            w_reg_write  = w_cond_ex;
            w_pc_write   = w_cond_ex && w_rd_pc;
         end
         S_MEMWR: begin
            w_adr_src   = 1'b1;
            w_mem_write = w_cond_ex;
         end
         S_EXECR, S_EXECI: begin
            w_alu_src_b = (r_state == S_EXECI) ? SRCB_IMM : SRCB_WDATA;
            w_alu_ctrl  = dp_alu_ctrl(w_cmd);
            w_next      = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write = r_exec_cond && !w_is_cmp;
            w_pc_write  = r_exec_cond && !w_is_cmp && w_rd_pc;
         end
         S_BRANCH: begin
            w_alu_src_b  = SRCB_IMM;
            w_imm_src    = IMM_BR24;
            w_result_src = RES_ALURESULT;
            w_pc_write   = w_cond_ex;
         end
         S_EXECMUL: begin
            if (w_long) w_alu_ctrl = w_signed ? ALU_SMULL : ALU_UMULL;
            else        w_alu_ctrl = ALU_MUL;
            w_next = S_MULWB;
         end
         S_MULWB: begin
            w_reg_write = r_exec_cond;
            w_long_wr   = r_exec_cond && w_long;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // write enables are held off combinationally while reset is low
   assign bus.PCWrite    = reset & w_pc_write;
   assign bus.RegWrite   = reset & w_reg_write;
   assign bus.IsLongMul  = reset & w_long_wr;
   assign bus.MemWrite   = reset & w_mem_write;
   assign bus.IRWrite    = reset & w_ir_write;
   assign bus.illegal    = reset & w_illegal;
   assign bus.AdrSrc     = w_adr_src;
   assign bus.RegSrc     = w_reg_src;
   assign bus.ALUSrcA    = w_alu_src_a;
   assign bus.ALUSrcB    = w_alu_src_b;
   assign bus.ResultSrc  = w_result_src;
   assign bus.ImmSrc     = w_imm_src;
   assign bus.ALUControl = w_alu_ctrl;
   assign bus.opMul      = w_is_mul;
   assign bus.state      = r_state;
   assign bus.Flags      = r_flags;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mc_controller_if bus ();

   mc_controller u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b0;
      bus.Instr    = 32'hE2821005;
      bus.ALUFlags = 4'b0000;
      tick();
      tick();
      check("rst_state", bus.state, 0);
      check("rst_flags", bus.Flags, 0);
      check("rst_pcwrite", bus.PCWrite, 0);
      check("rst_irwrite", bus.IRWrite, 0);
      reset = 1'b1;
      #1;

      // ADD R1,R2,#5
      check("add_fetch_state", bus.state, 0);
      check("add_fetch_irwrite", bus.IRWrite, 1);
      check("add_fetch_pcwrite", bus.PCWrite, 1);
      check("add_fetch_srcb", bus.ALUSrcB, 2);
      tick();
      check("add_decode_state", bus.state, 1);
      check("add_decode_regwrite", bus.RegWrite, 0);
      tick();
      check("add_execi_state", bus.state, 7);
      check("add_execi_aluctrl", bus.ALUControl, 0);
      check("add_execi_srcb", bus.ALUSrcB, 1);
      check("add_execi_regwrite", bus.RegWrite, 0);
      tick();
      check("add_aluwb_state", bus.state, 8);
      check("add_aluwb_regwrite", bus.RegWrite, 1);
      check("add_aluwb_pcwrite", bus.PCWrite, 0);
      tick();
      check("add_done_state", bus.state, 0);

      // CMP R1,R1 with ALU reporting Z
      bus.Instr = 32'hE1510001;
      tick();
      check("cmp_decode_state", bus.state, 1);
      tick();
      check("cmp_execr_state", bus.state, 6);
      check("cmp_execr_aluctrl", bus.ALUControl, 1);
      check("cmp_execr_srcb", bus.ALUSrcB, 0);
      bus.ALUFlags = 4'b0100;
      tick();
      bus.ALUFlags = 4'b0000;
      check("cmp_aluwb_state", bus.state, 8);
      check("cmp_flags", bus.Flags, 4'b0100);
      check("cmp_aluwb_regwrite", bus.RegWrite, 0);
      tick();

      // BNE not taken with Z=1
      bus.Instr = 32'h1A000000;
      tick();
      check("bne_decode_state", bus.state, 1);
      check("bne_decode_regsrc", bus.RegSrc, 1);
      tick();
      check("bne_branch_state", bus.state, 9);
      check("bne_branch_pcwrite", bus.PCWrite, 0);
      check("bne_branch_immsrc", bus.ImmSrc, 2);
      tick();
      check("bne_done_state", bus.state, 0);

      // ADDEQ executes with Z=1
      bus.Instr = 32'h02821005;
      tick();
      tick();
      check("addeq_execi_state", bus.state, 7);
      tick();
      check("addeq_aluwb_regwrite", bus.RegWrite, 1);
      check("addeq_flags_kept", bus.Flags, 4'b0100);
      tick();

      // LDR R3,[R0,#-8]
      bus.Instr = 32'hE5103008;
      tick();
      check("ldr_decode_regsrc", bus.RegSrc, 0);
      tick();
      check("ldr_memadr_state", bus.state, 2);
      check("ldr_memadr_aluctrl", bus.ALUControl, 1);
      check("ldr_memadr_immsrc", bus.ImmSrc, 1);
      tick();
      check("ldr_memrd_state", bus.state, 3);
      check("ldr_memrd_adrsrc", bus.AdrSrc, 1);
      tick();
      check("ldr_memwb_state", bus.state, 4);
      check("ldr_memwb_regwrite", bus.RegWrite, 1);
      check("ldr_memwb_resultsrc", bus.ResultSrc, 1);
      tick();
      check("ldr_done_state", bus.state, 0);

      // SMULL R4,R5,R1,R2
      bus.Instr = 32'hE0C54291;
      #1;
      check("smull_opmul", bus.opMul, 1);
      tick();
      tick();
      check("smull_execmul_state", bus.state, 10);
      check("smull_execmul_aluctrl", bus.ALUControl, 4'hA);
      tick();
      check("smull_mulwb_state", bus.state, 11);
      check("smull_mulwb_regwrite", bus.RegWrite, 1);
      check("smull_mulwb_longmul", bus.IsLongMul, 1);
      tick();

      // unsupported encoding
      bus.Instr = 32'hEC000000;
      tick();
      check("ill_decode_illegal", bus.illegal, 1);
      check("ill_decode_regwrite", bus.RegWrite, 0);
      check("ill_decode_memwrite", bus.MemWrite, 0);
      check("ill_decode_pcwrite", bus.PCWrite, 0);
      tick();
      check("ill_next_state", bus.state, 0);
      check("ill_pulse_once", bus.illegal, 0);

      // STR interrupted by reset in MEMWR
      bus.Instr = 32'hE5801000;
      tick();
      check("str_decode_regsrc", bus.RegSrc, 2);
      tick();
      check("str_memadr_aluctrl", bus.ALUControl, 0);
      tick();
      check("str_memwr_state", bus.state, 5);
      check("str_memwr_memwrite", bus.MemWrite, 1);
      reset = 1'b0;
      #1;
      check("str_rst_memwrite", bus.MemWrite, 0);
      check("str_rst_state", bus.state, 0);
      #1;
      reset = 1'b1;
      #1;
      check("str_rel_state", bus.state, 0);
      check("str_rel_flags", bus.Flags, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
